// File: rtl/ysyx_22040632_div_unit_pkg.sv
// Shared core package: ALU/MDU function codes and divider constants.
// Only the pieces the divide unit depends on are shown in this slice.
package ysyx_22040632_RISCV_PKG;

  localparam int DIV_W = 32;

  typedef enum logic [5:0] {
    FN_ADD   = 6'd0,
    FN_SUB   = 6'd1,
    FN_MULW  = 6'd32,
    FN_DIVW  = 6'd36,
    FN_DIVUW = 6'd37,
    FN_REMW  = 6'd38,
    FN_REMUW = 6'd39
  } func_t;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_BUSY = 2'd1,
    DS_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/ysyx_22040632_div_step.sv
// One restoring shift-subtract iteration of the W-bit divider.
// Partial remainder is always below divisor, so W+1 bits hold the diff sign.
module ysyx_22040632_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic         dbit,
  input  logic [W-1:0] dvsr,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] diff;

  assign shifted = {rem_in, dbit};
  assign diff    = shifted - {1'b0, dvsr};
  assign q_bit   = ~diff[W];
  assign rem_out = q_bit ? diff[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/ysyx_22040632_div_unit.sv
// Iterative 32-bit divide/remainder unit for the W-type RV64 ops.
// Divide-by-zero and signed overflow skip the iteration loop.
module ysyx_22040632_div_unit
  import ysyx_22040632_RISCV_PKG::*;
#(
  parameter int XLEN  = 64,
  parameter int DIV_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  func_t           in_func,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  div_state_e       state;
  logic [4:0]       cnt;
  logic [DIV_W-1:0] quo;
  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] dvsr;
  logic [DIV_W-1:0] res;
  logic             is_rem;
  logic             neg_q;
  logic             neg_r;
  logic             bypass;

  logic             is_op;
  logic             accept;
  logic             sgn;
  logic             rem_op;
  logic [DIV_W-1:0] a;
  logic [DIV_W-1:0] b;
  logic             a_neg;
  logic             b_neg;
  logic [DIV_W-1:0] a_abs;
  logic [DIV_W-1:0] b_abs;
  logic             div0;
  logic             ovf;
  logic [DIV_W-1:0] spec_res;

  logic [DIV_W-1:0] st_rem;
  logic             st_q;
  logic [DIV_W-1:0] q_fin;
  logic [DIV_W-1:0] r_fin;
  logic [DIV_W-1:0] fin_res;

  logic             unused_hi;

  assign unused_hi = ^{in_src1[XLEN-1:DIV_W], in_src2[XLEN-1:DIV_W]};

  assign is_op  = in_func inside {FN_DIVW, FN_DIVUW, FN_REMW, FN_REMUW};
  assign accept = in_valid && in_ready && is_op;
  assign sgn    = (in_func == FN_DIVW) || (in_func == FN_REMW);
  assign rem_op = (in_func == FN_REMW) || (in_func == FN_REMUW);

  assign a     = in_src1[DIV_W-1:0];
  assign b     = in_src2[DIV_W-1:0];
  assign a_neg = sgn && a[DIV_W-1];
  assign b_neg = sgn && b[DIV_W-1];
  assign a_abs = a_neg ? (~a + 1'b1) : a;
  assign b_abs = b_neg ? (~b + 1'b1) : b;

  assign div0 = (b == '0);
  assign ovf  = sgn && (a == {1'b1, {(DIV_W-1){1'b0}}})
             && (b == {DIV_W{1'b1}});

  always_comb begin
    spec_res = '0;
    unique case (1'b1)
      div0 && rem_op:   spec_res = a;
      div0 && !rem_op:  spec_res = '1;
      !div0 && rem_op:  spec_res = '0;
      default:          spec_res = {1'b1, {(DIV_W-1){1'b0}}};
    endcase
  end

  ysyx_22040632_div_step #(
    .W (DIV_W)
  ) u_step (
    .rem_in  (rem),
    .dbit    (quo[DIV_W-1]),
    .dvsr    (dvsr),
    .rem_out (st_rem),
    .q_bit   (st_q)
  );

  assign q_fin   = {quo[DIV_W-2:0], st_q};
  assign r_fin   = st_rem;
  assign fin_res = is_rem
                 ? (neg_r ? (~r_fin + 1'b1) : r_fin)
                 : (neg_q ? (~q_fin + 1'b1) : q_fin);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= DS_IDLE;
      cnt    <= '0;
      quo    <= '0;
      rem    <= '0;
      dvsr   <= '0;
      res    <= '0;
      is_rem <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      bypass <= 1'b0;
    end else if (flush) begin
      state <= DS_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        DS_IDLE: begin
          if (accept) begin
            state  <= DS_BUSY;
            cnt    <= '0;
            quo    <= a_abs;
            rem    <= '0;
            dvsr   <= b_abs;
            res    <= spec_res;
            is_rem <= rem_op;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            bypass <= div0 || ovf;
          end
        end
        DS_BUSY: begin
          if (bypass) begin
            state <= DS_DONE;
          end else begin
            rem <= st_rem;
            quo <= q_fin;
            cnt <= cnt + 5'd1;
            if (cnt == 5'd31) begin
              res   <= fin_res;
              state <= DS_DONE;
            end
          end
        end
        DS_DONE: begin
          if (out_ready) state <= DS_IDLE;
        end
        default: state <= DS_IDLE;
      endcase
    end
  end

  assign in_ready   = (state == DS_IDLE);
  assign out_valid  = (state == DS_DONE);
  assign out_result = {{(XLEN-DIV_W){res[DIV_W-1]}}, res};

endmodule

// File: tb/tb_ysyx_22040632_div_unit.sv
// Directed bench for the W-type divide unit.
// Expected values are hand-computed 64-bit results and cycle latencies.
module tb_ysyx_22040632_div_unit;
  import ysyx_22040632_RISCV_PKG::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  func_t       in_func;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;

  int nchk;
  int nerr;

  ysyx_22040632_div_unit #(
    .XLEN  (64),
    .DIV_W (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_func    (in_func),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input func_t f, input logic [63:0] s1,
                        input logic [63:0] s2, input int lat,
                        input logic [63:0] exp, input int hold,
                        input string tag);
    int n;
    logic [63:0] held;
    chk({tag, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1;
    in_func  = f;
    in_src1  = s1;
    in_src2  = s2;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, ".latency"}, 64'(n), 64'(lat));
    chk({tag, ".result"}, out_result, exp);
    held = out_result;
    for (int k = 0; k < hold; k++) begin
      tick();
      chk({tag, ".hold_valid"}, {63'd0, out_valid}, 64'd1);
      chk({tag, ".hold_result"}, out_result, held);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".idle_after"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  initial begin
    int seen;
    nchk      = 0;
    nerr      = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_func   = FN_ADD;
    in_src1   = '0;
    in_src2   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) tick();
    chk("reset.in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset.out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset.out_result", out_result, 64'd0);
    rst = 1'b0;
    tick();

    run_op(FN_DIVW, 64'd20, 64'd3, 32, 64'd6, 0, "divw_20_3");
    run_op(FN_REMW, 64'd20, 64'd3, 32, 64'd2, 0, "remw_20_3");
    run_op(FN_DIVW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 32,
           64'hFFFF_FFFF_FFFF_FFFD, 0, "divw_m7_2");
    run_op(FN_REMW, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 32,
           64'hFFFF_FFFF_FFFF_FFFF, 0, "remw_m7_2");
    run_op(FN_DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 32,
           64'hFFFF_FFFF_FFFF_FFFF, 0, "divuw_max_1");
    run_op(FN_REMUW, 64'h0000_0000_8000_0000, 64'd3, 32,
           64'd2, 0, "remuw_min_3");
    run_op(FN_DIVUW, 64'hDEAD_BEEF_0000_0014, 64'h1234_5678_0000_0003,
           32, 64'd6, 0, "divuw_hi_junk");
    run_op(FN_REMUW, 64'h0000_0000_8000_0005, 64'h0000_0000_8000_0000,
           32, 64'd5, 0, "remuw_big_div");
    run_op(FN_DIVW, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 32,
           64'hFFFF_FFFF_FFFF_FFFD, 0, "divw_7_m2");
    run_op(FN_REMW, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 32,
           64'd1, 0, "remw_7_m2");

    run_op(FN_DIVW, 64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0,
           "divw_5_0");
    run_op(FN_REMW, 64'd5, 64'd0, 1, 64'd5, 0, "remw_5_0");
    run_op(FN_REMUW, 64'h0000_0000_8000_0001, 64'd0, 1,
           64'hFFFF_FFFF_8000_0001, 0, "remuw_x_0");
    run_op(FN_DIVW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1,
           64'hFFFF_FFFF_8000_0000, 0, "divw_ovf");
    run_op(FN_REMW, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1,
           64'd0, 0, "remw_ovf");

    in_valid = 1'b1;
    in_func  = FN_ADD;
    in_src1  = 64'd9;
    in_src2  = 64'd3;
    tick();
    in_valid = 1'b0;
    chk("bad_func.in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    chk("bad_func.out_valid", {63'd0, out_valid}, 64'd0);

    in_valid = 1'b1;
    in_func  = FN_DIVW;
    in_src1  = 64'd100;
    in_src2  = 64'd7;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("flush.idle", {62'd0, in_ready, out_valid}, 64'd2);
    seen = 0;
    repeat (40) begin
      tick();
      if (out_valid) seen++;
    end
    chk("flush.no_valid", 64'(seen), 64'd0);
    run_op(FN_DIVW, 64'd9, 64'd3, 32, 64'd3, 0, "divw_9_3");

    in_valid = 1'b1;
    in_func  = FN_DIVW;
    in_src1  = 64'd50;
    in_src2  = 64'd5;
    tick();
    in_valid = 1'b0;
    repeat (15) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_busy.idle", {62'd0, in_ready, out_valid}, 64'd2);
    seen = 0;
    repeat (40) begin
      tick();
      if (out_valid) seen++;
    end
    chk("rst_busy.no_valid", 64'(seen), 64'd0);

    run_op(FN_DIVW, 64'd20, 64'd3, 32, 64'd6, 5, "hold_divw");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
